// File: rtl/fsk_pkg.sv
// Shared constants and types for the CPFSK modulator: tuning words, mode
// encoding, FSM states and the symbol-to-tone mapping.
package fsk_pkg;

    // Tuning words for a 24-bit accumulator at 100 MHz: 1 MHz base, 0.5 MHz spacing.
    localparam int unsigned F0_FTW = 167772;
    localparam int unsigned DF_FTW = 83886;

    typedef enum logic [1:0] {
        MODE_16FSK = 2'd0,
        MODE_8FSK  = 2'd1,
        MODE_4FSK  = 2'd2,
        MODE_2FSK  = 2'd3
    } fsk_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fsk_state_e;

    // Spread the reduced alphabets across the full 16-tone grid.
    function automatic logic [3:0] tone_index(input fsk_mode_e mode, input logic [3:0] data);
        logic [3:0] tone;
        case (mode)
            MODE_16FSK: tone = data;
            MODE_8FSK:  tone = {data[2:0], 1'b0};
            MODE_4FSK:  tone = {data[1:0], 2'b00};
            MODE_2FSK:  tone = {data[0], 3'b000};
            default:    tone = data;
        endcase
        return tone;
    endfunction

endpackage

// File: rtl/fsk_sine_lut.sv
// Quarter-wave sine magnitude ROM: mag = round(127*sin(pi/2*addr/64)).
module fsk_sine_lut (
    input  logic [5:0] addr,
    output logic [6:0] mag
);
    // NOTE: every path assigns mag (default arm included), so no latch is inferred.
    always_comb begin
        case (addr)
            6'd0:  mag = 7'd0;    6'd1:  mag = 7'd3;    6'd2:  mag = 7'd6;    6'd3:  mag = 7'd9;
            6'd4:  mag = 7'd12;   6'd5:  mag = 7'd16;   6'd6:  mag = 7'd19;   6'd7:  mag = 7'd22;
            6'd8:  mag = 7'd25;   6'd9:  mag = 7'd28;   6'd10: mag = 7'd31;   6'd11: mag = 7'd34;
            6'd12: mag = 7'd37;   6'd13: mag = 7'd40;   6'd14: mag = 7'd43;   6'd15: mag = 7'd46;
            6'd16: mag = 7'd49;   6'd17: mag = 7'd51;   6'd18: mag = 7'd54;   6'd19: mag = 7'd57;
            6'd20: mag = 7'd60;   6'd21: mag = 7'd63;   6'd22: mag = 7'd65;   6'd23: mag = 7'd68;
            6'd24: mag = 7'd71;   6'd25: mag = 7'd73;   6'd26: mag = 7'd76;   6'd27: mag = 7'd78;
            6'd28: mag = 7'd81;   6'd29: mag = 7'd83;   6'd30: mag = 7'd85;   6'd31: mag = 7'd88;
            6'd32: mag = 7'd90;   6'd33: mag = 7'd92;   6'd34: mag = 7'd94;   6'd35: mag = 7'd96;
            6'd36: mag = 7'd98;   6'd37: mag = 7'd100;  6'd38: mag = 7'd102;  6'd39: mag = 7'd104;
            6'd40: mag = 7'd106;  6'd41: mag = 7'd107;  6'd42: mag = 7'd109;  6'd43: mag = 7'd111;
            6'd44: mag = 7'd112;  6'd45: mag = 7'd113;  6'd46: mag = 7'd115;  6'd47: mag = 7'd116;
            6'd48: mag = 7'd117;  6'd49: mag = 7'd118;  6'd50: mag = 7'd120;  6'd51: mag = 7'd121;
            6'd52: mag = 7'd122;  6'd53: mag = 7'd122;  6'd54: mag = 7'd123;  6'd55: mag = 7'd124;
            6'd56: mag = 7'd125;  6'd57: mag = 7'd125;  6'd58: mag = 7'd126;  6'd59: mag = 7'd126;
            6'd60: mag = 7'd126;  6'd61: mag = 7'd127;  6'd62: mag = 7'd127;  6'd63: mag = 7'd127;
            default: mag = 7'd0;
        endcase
    end

endmodule

// File: rtl/fsk_modulator.sv
// Continuous-phase M-FSK modulator: one-entry symbol holding register, symbol
// timer, phase accumulator and quarter-wave sine lookup producing 8-bit samples.
module fsk_modulator
    import fsk_pkg::*;
#(
    parameter int SYMBOL_CYCLES = 100,
    parameter int PHASE_W       = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic [1:0] mode,
    input  logic [3:0] data_in,
    input  logic       sym_valid,
    output logic       sym_ready,
    output logic [7:0] sample_out,
    output logic       sample_valid,
    output logic       sym_strobe,
    output logic       underrun,
    output logic       busy
);

    localparam int CNT_W = (SYMBOL_CYCLES > 1) ? $clog2(SYMBOL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYMBOL_CYCLES - 1);

    fsk_state_e         state, state_next;
    logic [CNT_W-1:0]   sym_cnt;
    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] ftw;
    logic [3:0]         tone;
    logic [3:0]         hold_data;
    logic               hold_valid;
    logic               stop_pending;

    logic               start_now;
    logic               boundary;
    logic               stop_now;
    logic               load_now;
    logic               accept;

    logic [7:0]         quad_addr;
    logic [5:0]         lut_addr;
    logic [6:0]         lut_mag;
    logic [7:0]         sample_next;

    // FSM state register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (boundary && stop_now) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Boundary and handshake decodes; a pending stop pre-empts the load.
    always_comb begin
        busy      = (state == ST_RUN);
        start_now = (state == ST_IDLE) && start;
        boundary  = start_now || (busy && (sym_cnt == CNT_LAST));
        stop_now  = busy && (stop_pending || stop);
        load_now  = boundary && hold_valid && !stop_now;
        sym_ready = !hold_valid || load_now;
    end

    assign accept = sym_valid && sym_ready;
    assign ftw    = PHASE_W'(F0_FTW) + PHASE_W'(tone) * PHASE_W'(DF_FTW);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_data    <= '0;
            hold_valid   <= 1'b0;
            tone         <= '0;
            stop_pending <= 1'b0;
            sym_cnt      <= '0;
            phase        <= '0;
            sym_strobe   <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            if (accept) begin
                hold_data  <= data_in;
                hold_valid <= 1'b1;
            end else if (load_now) begin
                hold_valid <= 1'b0;
            end

            if (load_now) tone <= tone_index(fsk_mode_e'(mode), hold_data);

            sym_strobe <= load_now;
            underrun   <= boundary && !hold_valid && !stop_now;

            // Stop only matters in RUN; a stop alongside start in IDLE is dropped.
            if (!busy || (boundary && stop_now)) stop_pending <= 1'b0;
            else if (stop)                       stop_pending <= 1'b1;

            if (start_now)  sym_cnt <= '0;
            else if (busy)  sym_cnt <= (sym_cnt == CNT_LAST) ? '0 : sym_cnt + CNT_W'(1);

            if (start_now)  phase <= '0;
            else if (busy)  phase <= phase + ftw;
        end
    end

    // Quarter-wave folding: odd quadrants mirror the index, upper half negates.
    assign quad_addr = phase[PHASE_W-1 -: 8];
    assign lut_addr  = quad_addr[6] ? ~quad_addr[5:0] : quad_addr[5:0];

    fsk_sine_lut u_lut (
        .addr (lut_addr),
        .mag  (lut_mag)
    );

    assign sample_next = quad_addr[7] ? (8'd0 - {1'b0, lut_mag}) : {1'b0, lut_mag};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else if (busy && (state_next == ST_RUN)) begin
            sample_out   <= sample_next;
            sample_valid <= 1'b1;
        end else begin
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fsk_modulator.sv
// Self-checking bench for fsk_modulator: table of symbols/modes with expected
// tuning words, plus directed sweep, underrun, stop, reset and start/stop cases.
module tb_fsk_modulator;

    localparam int F0 = 167772;
    localparam int DF = 83886;
    localparam int SC = 100;

    logic       clk = 1'b0;
    logic       reset, start, stop, sym_valid;
    logic [1:0] mode;
    logic [3:0] data_in;
    logic       sym_ready, sample_valid, sym_strobe, underrun, busy;
    logic [7:0] sample_out;

    fsk_modulator #(.SYMBOL_CYCLES(SC), .PHASE_W(24)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .mode         (mode),
        .data_in      (data_in),
        .sym_valid    (sym_valid),
        .sym_ready    (sym_ready),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .sym_strobe   (sym_strobe),
        .underrun     (underrun),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        logic [3:0] data;
        int         ftw;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [23:0] m_phase;
    int          m_ftw;
    int          m_k;
    bit          m_run, m_stop;
    int          exp_q[$];
    int          off_ftw;
    bit          streaming;
    int          stream_next;
    int          s_max, s_min;
    vec_t        vecs[8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sine_model(input logic [23:0] ph);
        int  q   = int'(ph[23:22]);
        int  idx = int'(ph[21:16]);
        int  i   = (q % 2 == 1) ? 63 - idx : idx;
        real v   = 127.0 * $sin(3.14159265358979 * i / 128.0);
        int  mag = $rtoi(v + 0.5);
        return (q >= 2) ? -mag : mag;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [1:0] md, input logic [3:0] d, input int ftw);
        mode = md; data_in = d; sym_valid = 1'b1; off_ftw = ftw;
    endtask

    task automatic handle_accept(input bit acc);
        if (acc) begin
            exp_q.push_back(off_ftw);
            if (streaming && stream_next <= 15) begin
                data_in = 4'(stream_next);
                off_ftw = F0 + stream_next * DF;
                stream_next++;
            end else begin
                sym_valid = 1'b0;
            end
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " busy"}, int'(busy), 0);
        check({tag, " sample_valid"}, int'(sample_valid), 0);
        check({tag, " sample_out"}, int'($signed(sample_out)), 0);
        check({tag, " sym_strobe"}, int'(sym_strobe), 0);
        check({tag, " underrun"}, int'(underrun), 0);
    endtask

    task automatic tick();
        bit acc, bnd;
        #1;
        acc = sym_valid && sym_ready;
        bnd = (m_k % SC) == SC - 1;
        step();
        stop = 1'b0;
        if (bnd && m_stop) begin
            check_quiet("stop boundary");
            m_run = 1'b0; m_stop = 1'b0;
            handle_accept(acc);
            return;
        end
        check($sformatf("sample k=%0d", m_k + 1), int'($signed(sample_out)), sine_model(m_phase));
        check("run sample_valid", int'(sample_valid), 1);
        check("run busy", int'(busy), 1);
        if (int'($signed(sample_out)) > s_max) s_max = int'($signed(sample_out));
        if (int'($signed(sample_out)) < s_min) s_min = int'($signed(sample_out));
        m_phase = m_phase + 24'(m_ftw);
        if (bnd) begin
            if (exp_q.size() > 0) begin
                m_ftw = exp_q.pop_front();
                check($sformatf("strobe at k=%0d", m_k + 1), int'(sym_strobe), 1);
                check($sformatf("no underrun at k=%0d", m_k + 1), int'(underrun), 0);
            end else begin
                check($sformatf("no strobe at k=%0d", m_k + 1), int'(sym_strobe), 0);
                check($sformatf("underrun at k=%0d", m_k + 1), int'(underrun), 1);
            end
        end else begin
            check("mid strobe", int'(sym_strobe), 0);
            check("mid underrun", int'(underrun), 0);
        end
        handle_accept(acc);
        m_k++;
    endtask

    task automatic do_start();
        bit acc;
        start = 1'b1;
        #1;
        acc = sym_valid && sym_ready;
        step();
        start = 1'b0; stop = 1'b0;
        m_phase = '0; m_k = 0; m_run = 1'b1; m_stop = 1'b0;
        check("start busy", int'(busy), 1);
        check("start sample_valid", int'(sample_valid), 0);
        check("start sample_out", int'($signed(sample_out)), 0);
        if (exp_q.size() > 0) begin
            m_ftw = exp_q.pop_front();
            check("start strobe", int'(sym_strobe), 1);
            check("start underrun", int'(underrun), 0);
        end else begin
            check("start strobe", int'(sym_strobe), 0);
            check("start underrun", int'(underrun), 1);
        end
        handle_accept(acc);
    endtask

    task automatic idle_step();
        bit acc;
        #1;
        acc = sym_valid && sym_ready;
        step();
        check_quiet("idle");
        handle_accept(acc);
    endtask

    task automatic run_until_idle(input int max_cycles);
        for (int i = 0; i < max_cycles && m_run; i++) tick();
        check("reached idle", int'(m_run), 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{2'd0, 4'd0,  167772};
        vecs[1] = '{2'd0, 4'd15, 1426062};
        vecs[2] = '{2'd3, 4'd1,  838860};
        vecs[3] = '{2'd3, 4'd14, 167772};
        vecs[4] = '{2'd1, 4'd5,  1006632};
        vecs[5] = '{2'd2, 4'd3,  1174404};
        vecs[6] = '{2'd1, 4'd15, 1342176};
        vecs[7] = '{2'd2, 4'd6,  838860};

        reset = 1'b1; start = 1'b0; stop = 1'b0; sym_valid = 1'b0;
        mode = 2'd0; data_in = 4'd0;
        m_ftw = F0; m_k = 0; m_run = 1'b0; m_stop = 1'b0; streaming = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_quiet("in reset");
        check("in reset sym_ready", int'(sym_ready), 1);
        reset = 1'b0;
        step();
        check_quiet("after reset");

        // Table: one symbol per vector, mode perturbed after load, stop at counter 40.
        for (int v = 0; v < 8; v++) begin
            s_max = -1000; s_min = 1000;
            offer(vecs[v].mode, vecs[v].data, vecs[v].ftw);
            idle_step();
            check($sformatf("vec%0d held in idle sym_ready", v), int'(sym_ready), 0);
            do_start();
            mode = ~vecs[v].mode;
            repeat (40) tick();
            stop = 1'b1; m_stop = 1'b1;
            tick();
            run_until_idle(200);
            if (v == 0) begin
                check("tone0 positive peak", s_max, 127);
                check("tone0 negative peak", s_min, -127);
            end
        end

        // Back-to-back sweep of all 16 tones, then an underrun boundary.
        mode = 2'd0;
        streaming = 1'b1; stream_next = 1;
        offer(2'd0, 4'd0, F0);
        idle_step();
        do_start();
        repeat (1600) tick();
        streaming = 1'b0;
        check("post-underrun sym_ready", int'(sym_ready), 1);
        repeat (40) tick();
        stop = 1'b1; m_stop = 1'b1;
        tick();
        repeat (9) tick();
        offer(2'd0, 4'd3, F0 + 3 * DF);
        run_until_idle(200);
        check("stopped with held symbol sym_ready", int'(sym_ready), 0);
        idle_step();
        idle_step();
        do_start();
        repeat (30) tick();

        // Asynchronous reset mid-symbol.
        reset = 1'b1;
        #1;
        check("mid-run reset sample_out", int'($signed(sample_out)), 0);
        check("mid-run reset busy", int'(busy), 0);
        check("mid-run reset sym_ready", int'(sym_ready), 1);
        check("mid-run reset sample_valid", int'(sample_valid), 0);
        step();
        reset = 1'b0;
        exp_q.delete();
        m_ftw = F0; m_run = 1'b0;
        step();
        check_quiet("post reset");

        // Start together with stop: start wins, tone 0 after reset, underrun on both boundaries.
        stop = 1'b1;
        do_start();
        repeat (110) tick();
        check("start+stop still running", int'(busy), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
